// File: rtl/rsa_feeder_if.sv
// Operand-feeder bundle: start/base request, A/B memory read ports, array streams, status.
// Latency: none (wiring only); read data returns one cycle after its strobe.
// Backpressure: none; the array input FIFOs accept every valid beat.
interface rsa_feeder_if #(
    parameter int IN_LEN = 8,
    parameter int MEM_AW = 8
);
    logic              start;
    logic [MEM_AW-1:0] base_a;
    logic [MEM_AW-1:0] base_b;
    logic              a_rd_en;
    logic              b_rd_en;
    logic [MEM_AW-1:0] a_addr;
    logic [MEM_AW-1:0] b_addr;
    logic [IN_LEN-1:0] a_rd_data;
    logic [IN_LEN-1:0] b_rd_data;
    logic              Xin_val;
    logic [IN_LEN-1:0] Xin_data;
    logic              Yin_val;
    logic [IN_LEN-1:0] Yin_data;
    logic              SA_start;
    logic              busy;
    logic              done;

    // Feeder side: takes requests and read data, drives strobes, streams and status.
    modport master (
        input  start, base_a, base_b, a_rd_data, b_rd_data,
        output a_rd_en, b_rd_en, a_addr, b_addr,
               Xin_val, Xin_data, Yin_val, Yin_data, SA_start, busy, done
    );

    // Environment side: controller, operand memories and the systolic array.
    modport slave (
        output start, base_a, base_b, a_rd_data, b_rd_data,
        input  a_rd_en, b_rd_en, a_addr, b_addr,
               Xin_val, Xin_data, Yin_val, Yin_data, SA_start, busy, done
    );
endinterface

// File: rtl/rsa_feeder.sv
// Streams A row-major and B column-major from operand memories into a systolic array, then kicks it.
// Latency: strobes 1 cycle after accepted start, vals 1 cycle later, SA_start/done at max(X*N,N*Y)+2.
// Backpressure: none; one read per cycle per port, downstream always accepts.
module rsa_feeder #(
    parameter int X      = 3,
    parameter int N      = 4,
    parameter int Y      = 3,
    parameter int IN_LEN = 8,
    parameter int MEM_AW = 8
) (
    input  logic          clk,
    input  logic          sys_rst_n,
    rsa_feeder_if.master  bus
);
    localparam int A_CNT = X * N;
    localparam int B_CNT = N * Y;
    localparam int L_MAX = (A_CNT > B_CNT) ? A_CNT : B_CNT;
    localparam int CW    = $clog2(L_MAX + 1);
    localparam int KW    = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_KICK  = 2'd3
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_a_cnt;
    logic [CW-1:0]     r_b_cnt;
    logic [KW-1:0]     r_b_k;
    logic [MEM_AW-1:0] r_b_col;
    logic              r_a_rd_en;
    logic              r_b_rd_en;
    logic [MEM_AW-1:0] r_a_addr;
    logic [MEM_AW-1:0] r_b_addr;
    logic              r_xin_val;
    logic              r_yin_val;
    logic              r_sa_start;
    logic              r_done;
    logic              r_busy;

    // Counters hold the number of reads already issued on each port.
    logic w_a_more;
    logic w_b_more;
    logic w_b_col_end;

    assign w_a_more    = (r_a_cnt < CW'(A_CNT));
    assign w_b_more    = (r_b_cnt < CW'(B_CNT));
    assign w_b_col_end = (r_b_k == KW'(N - 1));

    // Control FSM and read-address generation; all outputs registered.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= S_IDLE;
            r_a_cnt    <= '0;
            r_b_cnt    <= '0;
            r_b_k      <= '0;
            r_b_col    <= '0;
            r_a_rd_en  <= 1'b0;
            r_b_rd_en  <= 1'b0;
            r_a_addr   <= '0;
            r_b_addr   <= '0;
            r_sa_start <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_sa_start <= 1'b0;
                    r_done     <= 1'b0;
                    if (bus.start) begin
                        // First read of each stream goes out in the very first FETCH cycle.
                        r_state   <= S_FETCH;
                        r_busy    <= 1'b1;
                        r_a_rd_en <= 1'b1;
                        r_a_addr  <= bus.base_a;
                        r_a_cnt   <= CW'(1);
                        r_b_rd_en <= 1'b1;
                        r_b_addr  <= bus.base_b;
                        r_b_col   <= bus.base_b;
                        r_b_k     <= '0;
                        r_b_cnt   <= CW'(1);
                    end
                end
                S_FETCH: begin
                    // A is contiguous row-major, so its address just increments.
                    if (w_a_more) begin
                        r_a_rd_en <= 1'b1;
                        r_a_addr  <= r_a_addr + MEM_AW'(1);
                        r_a_cnt   <= r_a_cnt + CW'(1);
                    end else begin
                        r_a_rd_en <= 1'b0;
                    end
                    // B walks down a column with stride Y, then hops to the next column head.
                    if (w_b_more) begin
                        r_b_rd_en <= 1'b1;
                        r_b_cnt   <= r_b_cnt + CW'(1);
                        if (w_b_col_end) begin
                            r_b_col  <= r_b_col + MEM_AW'(1);
                            r_b_addr <= r_b_col + MEM_AW'(1);
                            r_b_k    <= '0;
                        end else begin
                            r_b_addr <= r_b_addr + MEM_AW'(Y);
                            r_b_k    <= r_b_k + KW'(1);
                        end
                    end else begin
                        r_b_rd_en <= 1'b0;
                    end
                    if (!w_a_more && !w_b_more) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Last read data lands in this cycle; launch the array next.
                    r_state    <= S_KICK;
                    r_sa_start <= 1'b1;
                    r_done     <= 1'b1;
                end
                S_KICK: begin
                    r_state    <= S_IDLE;
                    r_sa_start <= 1'b0;
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stream valids follow the strobes by the one-cycle memory read latency.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_xin_val <= 1'b0;
            r_yin_val <= 1'b0;
        end else begin
            r_xin_val <= r_a_rd_en;
            r_yin_val <= r_b_rd_en;
        end
    end

    assign bus.a_rd_en  = r_a_rd_en;
    assign bus.b_rd_en  = r_b_rd_en;
    assign bus.a_addr   = r_a_addr;
    assign bus.b_addr   = r_b_addr;
    assign bus.Xin_val  = r_xin_val;
    assign bus.Yin_val  = r_yin_val;
    // Memory data is passed straight through, forced to zero outside valid beats.
    assign bus.Xin_data = r_xin_val ? bus.a_rd_data : '0;
    assign bus.Yin_data = r_yin_val ? bus.b_rd_data : '0;
    assign bus.SA_start = r_sa_start;
    assign bus.done     = r_done;
    assign bus.busy     = r_busy;
endmodule

// File: tb/tb_rsa_feeder.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and compares.
// Latency: checks exact cycle of every strobe, data beat and kick.
// Backpressure: none exercised; the feeder has no flow control.
module tb_rsa_feeder;
    logic clk = 1'b0;
    logic sys_rst_n = 1'b0;
    int   cnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   busy_lo [2];
    int   busy_hi [2];

    // kind: 0 a_addr, 1 b_addr, 2 Xin_data, 3 Yin_data, 4 SA_start
    typedef struct {
        int d;
        int kind;
        int cyc;
        int val;
    } exp_t;
    exp_t  sb [$];
    string kname [5] = '{"a_addr", "b_addr", "xin_data", "yin_data", "sa_start"};

    rsa_feeder_if #(.IN_LEN(8), .MEM_AW(8)) bus0 ();
    rsa_feeder_if #(.IN_LEN(8), .MEM_AW(8)) bus1 ();

    rsa_feeder #(.X(3), .N(4), .Y(3), .IN_LEN(8), .MEM_AW(8)) u_dut0 (
        .clk(clk), .sys_rst_n(sys_rst_n), .bus(bus0));
    rsa_feeder #(.X(2), .N(4), .Y(3), .IN_LEN(8), .MEM_AW(8)) u_dut1 (
        .clk(clk), .sys_rst_n(sys_rst_n), .bus(bus1));

    always #5 clk = ~clk;

    always @(posedge clk) cnt++;

    function automatic logic [7:0] mem_a(input logic [7:0] a);
        return a ^ 8'h3C;
    endfunction

    function automatic logic [7:0] mem_b(input logic [7:0] a);
        return a + 8'h71;
    endfunction

    // Synchronous operand memories; idle read data is junk so gating is observable.
    always @(posedge clk) begin
        bus0.a_rd_data = bus0.a_rd_en ? mem_a(bus0.a_addr) : 8'hEE;
        bus0.b_rd_data = bus0.b_rd_en ? mem_b(bus0.b_addr) : 8'hEE;
        bus1.a_rd_data = bus1.a_rd_en ? mem_a(bus1.a_addr) : 8'hEE;
        bus1.b_rd_data = bus1.b_rd_en ? mem_b(bus1.b_addr) : 8'hEE;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cnt, act, exp);
        end
    endtask

    task automatic match(input int d, input int kind, input int v);
        int idx;
        idx = -1;
        foreach (sb[i]) if (idx < 0 && sb[i].d == d && sb[i].kind == kind) idx = i;
        if (idx < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dut%0d unexpected %s @cyc %0d: got %0h expected no beat", d, kname[kind], cnt, v);
        end else begin
            check($sformatf("dut%0d %s cycle", d, kname[kind]), cnt, sb[idx].cyc);
            check($sformatf("dut%0d %s value", d, kname[kind]), v, sb[idx].val);
            sb.delete(idx);
        end
    endtask

    task automatic observe(input int d, input logic a_en, input logic [7:0] a_ad,
                           input logic b_en, input logic [7:0] b_ad,
                           input logic xv, input logic [7:0] xd,
                           input logic yv, input logic [7:0] yd,
                           input logic sa, input logic dn, input logic bz);
        logic exp_busy;
        if (a_en) match(d, 0, int'(a_ad));
        if (b_en) match(d, 1, int'(b_ad));
        if (xv) match(d, 2, int'(xd));
        else check($sformatf("dut%0d xin_data idle", d), xd, 0);
        if (yv) match(d, 3, int'(yd));
        else check($sformatf("dut%0d yin_data idle", d), yd, 0);
        if (sa || dn) begin
            check($sformatf("dut%0d done==sa_start", d), dn, sa);
            match(d, 4, 0);
        end
        exp_busy = (cnt >= busy_lo[d]) && (cnt <= busy_hi[d]);
        check($sformatf("dut%0d busy", d), bz, exp_busy);
    endtask

    // Monitor: samples both DUTs mid-cycle.
    always @(negedge clk) begin
        observe(0, bus0.a_rd_en, bus0.a_addr, bus0.b_rd_en, bus0.b_addr, bus0.Xin_val,
                bus0.Xin_data, bus0.Yin_val, bus0.Yin_data, bus0.SA_start, bus0.done, bus0.busy);
        observe(1, bus1.a_rd_en, bus1.a_addr, bus1.b_rd_en, bus1.b_addr, bus1.Xin_val,
                bus1.Xin_data, bus1.Yin_val, bus1.Yin_data, bus1.SA_start, bus1.done, bus1.busy);
    end

    task automatic set_start(input int d, input logic v, input logic [7:0] ba, input logic [7:0] bb);
        if (d == 0) begin
            bus0.start = v; bus0.base_a = ba; bus0.base_b = bb;
        end else begin
            bus1.start = v; bus1.base_a = ba; bus1.base_b = bb;
        end
    endtask

    // Called #1 after an edge: start is high for the current cycle and sampled at the next edge.
    task automatic launch(input int d, input int ba, input int bb, input int xx,
                          input int nn, input int yy, output int s);
        int L;
        logic [7:0] ad;
        set_start(d, 1'b1, 8'(ba), 8'(bb));
        @(posedge clk);
        #1;
        set_start(d, 1'b0, 8'h00, 8'h00);
        s = cnt;
        L = (xx * nn > nn * yy) ? xx * nn : nn * yy;
        for (int n = 0; n < xx * nn; n++) begin
            ad = 8'((ba + n) % 256);
            sb.push_back('{d, 0, s + n, int'(ad)});
            sb.push_back('{d, 2, s + n + 1, int'(mem_a(ad))});
        end
        for (int j = 0; j < yy; j++) begin
            for (int k = 0; k < nn; k++) begin
                ad = 8'((bb + k * yy + j) % 256);
                sb.push_back('{d, 1, s + j * nn + k, int'(ad)});
                sb.push_back('{d, 3, s + j * nn + k + 1, int'(mem_b(ad))});
            end
        end
        sb.push_back('{d, 4, s + L + 1, 0});
        busy_lo[d] = s;
        busy_hi[d] = s + L + 1;
    endtask

    // A start pulse that must be ignored; bases differ so a wrong latch shows up.
    task automatic pulse_ignored(input int d);
        set_start(d, 1'b1, 8'h77, 8'h99);
        @(posedge clk);
        #1;
        set_start(d, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic wait_cyc(input int c);
        if (c < cnt) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_cyc: now %0d target %0d", cnt, c);
        end
        while (cnt < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, " dut0 outs"}, {bus0.a_rd_en, bus0.b_rd_en, bus0.a_addr, bus0.b_addr,
              bus0.Xin_val, bus0.Xin_data, bus0.Yin_val}, 0);
        check({nm, " dut0 outs2"}, {bus0.Yin_data, bus0.SA_start, bus0.busy, bus0.done}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int s1, s2, s3, s4, s5;
        busy_lo[0] = 1; busy_hi[0] = 0;
        busy_lo[1] = 1; busy_hi[1] = 0;
        set_start(0, 1'b0, 8'h00, 8'h00);
        set_start(1, 1'b0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset dut1 outs", {bus1.a_rd_en, bus1.b_rd_en, bus1.a_addr, bus1.b_addr,
              bus1.Xin_val, bus1.Yin_val, bus1.SA_start, bus1.busy, bus1.done}, 0);
        sys_rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Nominal 3x4x3 product, with ignored starts in cycles 5 and 14 (the KICK cycle).
        launch(0, 0, 16, 3, 4, 3, s1);
        wait_cyc(s1 + 4);
        pulse_ignored(0);
        wait_cyc(s1 + 13);
        pulse_ignored(0);
        // Now in cycle 15: first IDLE cycle, accepted; A base wraps past 255.
        launch(0, 250, 100, 3, 4, 3, s2);
        wait_cyc(s2 + 16);

        // Reset in cycle 7 for two cycles aborts the transfer.
        launch(0, 0, 16, 3, 4, 3, s3);
        wait_cyc(s3 + 6);
        sys_rst_n = 1'b0;
        for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].d == 0) sb.delete(i);
        busy_lo[0] = 1; busy_hi[0] = 0;
        #1;
        check_all_zero("abort reset");
        @(posedge clk);
        #1;
        check_all_zero("abort reset held");
        sys_rst_n = 1'b1;
        launch(0, 0, 16, 3, 4, 3, s4);
        wait_cyc(s4 + 16);

        // Shorter A stream: X=2 finishes at cycle 8, B runs to 12, kick at 14.
        launch(1, 40, 200, 2, 4, 3, s5);
        wait_cyc(s5 + 20);

        foreach (sb[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dut%0d missing %s: got none expected %0h at cyc %0d",
                     sb[i].d, kname[sb[i].kind], sb[i].val, sb[i].cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
